// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory stage: access sizes, fault codes and FSM states.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_ILL  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_DBG     = 2'b10
    } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Pipeline request/response bus plus debug word-read port of the data-memory stage.
interface mem_stage_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) ();
    localparam int DBG_AW = $clog2(DEPTH);

    logic                  i_valid;
    logic                  o_ready;
    logic                  i_memread;
    logic                  i_memwrite;
    logic [1:0]            i_sizemem;
    logic                  i_signedmem;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [DATA_WIDTH-1:0] i_datawrite;
    logic                  o_rdvalid;
    logic [DATA_WIDTH-1:0] o_dataread;
    logic                  o_fault;
    logic [1:0]            o_fault_code;
    logic                  i_dbg_en;
    logic [DBG_AW-1:0]     i_dbg_addr;
    logic [DATA_WIDTH-1:0] o_dbg_data;

    modport master (
        output i_valid, i_memread, i_memwrite, i_sizemem, i_signedmem, i_address, i_datawrite,
        output i_dbg_en, i_dbg_addr,
        input  o_ready, o_rdvalid, o_dataread, o_fault, o_fault_code, o_dbg_data
    );

    modport slave (
        input  i_valid, i_memread, i_memwrite, i_sizemem, i_signedmem, i_address, i_datawrite,
        input  i_dbg_en, i_dbg_addr,
        output o_ready, o_rdvalid, o_dataread, o_fault, o_fault_code, o_dbg_data
    );
endinterface

// File: rtl/mem_datos_ram.sv
// Word-organised synchronous RAM: byte-enabled write port, registered read port. Contents never reset.
module mem_datos_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [3:0]                 be,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS MEM stage: one load/store per handshake, lane-aligned stores, extended loads,
// request fault detection and a debug word-read port that holds off the pipeline.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input logic             i_clock,
    input logic             i_reset,
    mem_stage_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_IDX = (ADDR_WIDTH-2)'(DEPTH);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            off, code;
    logic                  ready, accept, is_ill, is_mis, is_oor, req_fault, we, ld_go;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    logic [AW-1:0]         raddr;
    logic [1:0]            ld_size_p1, ld_off_p1;
    logic                  ld_sgn_p1;
    logic                  rdvalid_p2, fault_p1, dbg_live;
    logic [1:0]            fault_code_p1;
    logic [DATA_WIDTH-1:0] dataread_p2, dbg_hold;

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] w,
                                                          input logic [1:0] sz, input logic sgn,
                                                          input logic [1:0] o);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{o, 3'b000} +: 8];
        h = w[{o[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    assign word_idx = bus.i_address[ADDR_WIDTH-1:2];
    assign off      = bus.i_address[1:0];
    // Ready is held low while in reset even though the state register already reads IDLE.
    assign ready    = i_reset && (state == ST_IDLE) && !bus.i_dbg_en;
    assign accept   = bus.i_valid && ready && (bus.i_memread || bus.i_memwrite);

    always_comb begin
        is_ill = (bus.i_memread && bus.i_memwrite) || (bus.i_sizemem == SZ_ILL);
        is_mis = ((bus.i_sizemem == SZ_HALF) && off[0]) ||
                 ((bus.i_sizemem == SZ_WORD) && (off != 2'b00));
        is_oor = (word_idx >= DEPTH_IDX);
        if (is_ill)      code = FLT_ILLEGAL;
        else if (is_mis) code = FLT_MISALIGN;
        else if (is_oor) code = FLT_RANGE;
        else             code = FLT_NONE;
    end

    assign req_fault = accept && (code != FLT_NONE);
    assign we        = accept && bus.i_memwrite && !req_fault;
    assign ld_go     = accept && bus.i_memread && !req_fault;

    // Store data is replicated across lanes; byte enables pick the addressed ones.
    always_comb begin
        wdata = bus.i_datawrite;
        be    = 4'b0000;
        case (bus.i_sizemem)
            SZ_BYTE: begin wdata = {4{bus.i_datawrite[7:0]}};  be = 4'b0001 << off; end
            SZ_HALF: begin wdata = {2{bus.i_datawrite[15:0]}}; be = off[1] ? 4'b1100 : 4'b0011; end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign raddr = (state == ST_DBG) ? bus.i_dbg_addr : word_idx[AW-1:0];

    mem_datos_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (i_clock),
        .we    (we),
        .be    (be),
        .waddr (word_idx[AW-1:0]),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bus.i_dbg_en) state_nx = ST_DBG;
                        else if (ld_go)   state_nx = ST_RD_WAIT;
            ST_RD_WAIT: state_nx = bus.i_dbg_en ? ST_DBG : ST_IDLE;
            ST_DBG:     if (!bus.i_dbg_en) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // p1: accepted request decoded; p2: RAM word extended into the load result
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            ld_size_p1    <= SZ_BYTE;
            ld_sgn_p1     <= 1'b0;
            ld_off_p1     <= 2'b00;
            fault_p1      <= 1'b0;
            fault_code_p1 <= FLT_NONE;
            rdvalid_p2    <= 1'b0;
            dataread_p2   <= '0;
            dbg_live      <= 1'b0;
            dbg_hold      <= '0;
        end else begin
            state    <= state_nx;
            fault_p1 <= req_fault;
            if (req_fault) fault_code_p1 <= code;
            if (ld_go) begin
                ld_size_p1 <= bus.i_sizemem;
                ld_sgn_p1  <= bus.i_signedmem;
                ld_off_p1  <= off;
            end
            rdvalid_p2 <= (state == ST_RD_WAIT);
            if (state == ST_RD_WAIT) dataread_p2 <= load_extend(rdata, ld_size_p1, ld_sgn_p1, ld_off_p1);
            dbg_live <= (state == ST_DBG) && bus.i_dbg_en;
            dbg_hold <= bus.o_dbg_data;
        end
    end

    // The RAM read register doubles as the debug output while a debug read is live.
    assign bus.o_dbg_data   = dbg_live ? rdata : dbg_hold;
    assign bus.o_ready      = ready;
    assign bus.o_rdvalid    = rdvalid_p2;
    assign bus.o_dataread   = dataread_p2;
    assign bus.o_fault      = fault_p1;
    assign bus.o_fault_code = fault_code_p1;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios then random traffic against a byte-array reference model.
module tb_mem_stage_ctrl;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] last_data = 32'h0;
    logic [1:0]  last_code = 2'b00;
    logic [7:0]  mdl [DEPTH*4];

    mem_stage_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) bus ();

    mem_stage_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [1:0] model_fault(input logic rd, input logic wr, input logic [1:0] sz,
                                               input logic [31:0] addr);
        if (!(rd || wr)) return 2'd0;
        if ((rd && wr) || sz == 2'b10) return 2'd3;
        if ((sz == 2'b01 && addr % 2 != 0) || (sz == 2'b11 && addr % 4 != 0)) return 2'd1;
        if (addr / 4 >= DEPTH) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg);
        longint v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[addr + i]) << (8 * i);
        if (sg && n < 4 && v[8*n-1]) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_word(input int idx);
        return model_load(32'(idx * 4), 2'b11, 1'b0);
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) mdl[addr + i] = 8'(d >> (8 * i));
    endtask

    task automatic op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [31:0] addr, input logic [31:0] d);
        logic [1:0] fc;
        logic [31:0] exp;
        fc = model_fault(rd, wr, sz, addr);
        chk(tag, "ready_in", 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1; bus.i_memread = rd; bus.i_memwrite = wr; bus.i_sizemem = sz;
        bus.i_signedmem = sg; bus.i_address = addr; bus.i_datawrite = d;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_memread = 1'b0; bus.i_memwrite = 1'b0;
        if (fc != 2'd0) last_code = fc;
        chk(tag, "fault", 32'(bus.o_fault), 32'(fc != 2'd0));
        chk(tag, "code", 32'(bus.o_fault_code), 32'(last_code));
        chk(tag, "rdvalid_early", 32'(bus.o_rdvalid), 32'd0);
        if (fc == 2'd0 && rd) begin
            chk(tag, "ready_wait", 32'(bus.o_ready), 32'd0);
            @(posedge clk); #1;
            exp = model_load(addr, sz, sg);
            last_data = exp;
            chk(tag, "rdvalid", 32'(bus.o_rdvalid), 32'd1);
            chk(tag, "data", bus.o_dataread, exp);
        end else begin
            if (fc == 2'd0 && wr) model_store(addr, sz, d);
            chk(tag, "ready_after", 32'(bus.o_ready), 32'd1);
            chk(tag, "data_hold", bus.o_dataread, last_data);
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0] sz;
        int kind;
        bus.i_valid = 1'b0; bus.i_memread = 1'b0; bus.i_memwrite = 1'b0; bus.i_sizemem = 2'b00;
        bus.i_signedmem = 1'b0; bus.i_address = '0; bus.i_datawrite = '0;
        bus.i_dbg_en = 1'b0; bus.i_dbg_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset", "ready", 32'(bus.o_ready), 32'd0);
        chk("reset", "rdvalid", 32'(bus.o_rdvalid), 32'd0);
        chk("reset", "fault", 32'(bus.o_fault), 32'd0);
        chk("reset", "code", 32'(bus.o_fault_code), 32'd0);
        chk("reset", "data", bus.o_dataread, 32'd0);
        chk("reset", "dbg", bus.o_dbg_data, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release", "ready", 32'(bus.o_ready), 32'd1);

        op("sw10", 1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
        op("lb13", 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        chk("lb13", "const", bus.o_dataread, 32'hFFFFFFDE);
        op("lhu12", 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        chk("lhu12", "const", bus.o_dataread, 32'h0000DEAD);
        op("lh10", 1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        chk("lh10", "const", bus.o_dataread, 32'hFFFFBEEF);
        op("lbu10", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        chk("lbu10", "const", bus.o_dataread, 32'h000000EF);
        op("sb11", 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F);
        op("lw10", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("lw10", "const", bus.o_dataread, 32'hDEAD7FEF);

        op("b2b0", 1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h11223344);
        op("b2b1", 1'b0, 1'b1, 2'b01, 1'b0, 32'h26, 32'h0000A5A5);
        op("b2b2", 1'b0, 1'b1, 2'b00, 1'b0, 32'h24, 32'h000000C3);
        op("b2b3", 1'b0, 1'b1, 2'b00, 1'b0, 32'h25, 32'h0000003C);
        op("lw20", 1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        op("lw24", 1'b1, 1'b0, 2'b11, 1'b0, 32'h24, 32'h0);
        chk("lw24", "const", bus.o_dataread, 32'hA5A53CC3);

        op("lw02", 1'b1, 1'b0, 2'b11, 1'b0, 32'h02, 32'h0);
        chk("lw02", "const", 32'(bus.o_fault_code), 32'd1);
        op("sh401", 1'b0, 1'b1, 2'b01, 1'b0, 32'h401, 32'hFFFF);
        chk("sh401", "const", 32'(bus.o_fault_code), 32'd1);
        op("lw400", 1'b1, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0);
        chk("lw400", "const", 32'(bus.o_fault_code), 32'd2);
        op("rdwr", 1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("rdwr", "const", 32'(bus.o_fault_code), 32'd3);
        op("sz10", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        op("sw12", 1'b0, 1'b1, 2'b11, 1'b0, 32'h12, 32'h12345678);
        op("noop", 1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        op("lw10b", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("lw10b", "const", bus.o_dataread, 32'hDEAD7FEF);

        // Load in flight when the debug unit asks for the memory
        bus.i_dbg_addr = 8'd4;
        bus.i_valid = 1'b1; bus.i_memread = 1'b1; bus.i_sizemem = 2'b11; bus.i_address = 32'h20;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_memread = 1'b0; bus.i_dbg_en = 1'b1;
        chk("dbg", "ready_wait", 32'(bus.o_ready), 32'd0);
        chk("dbg", "rdvalid_early", 32'(bus.o_rdvalid), 32'd0);
        @(posedge clk); #1;
        last_data = model_load(32'h20, 2'b11, 1'b0);
        chk("dbg", "rdvalid", 32'(bus.o_rdvalid), 32'd1);
        chk("dbg", "load_data", bus.o_dataread, last_data);
        chk("dbg", "ready_ld", 32'(bus.o_ready), 32'd0);
        @(posedge clk); #1;
        chk("dbg", "rdvalid_off", 32'(bus.o_rdvalid), 32'd0);
        chk("dbg", "word4", bus.o_dbg_data, model_word(4));
        chk("dbg", "word4_const", bus.o_dbg_data, 32'hDEAD7FEF);
        chk("dbg", "ready_dbg", 32'(bus.o_ready), 32'd0);
        bus.i_dbg_addr = 8'd8;
        bus.i_valid = 1'b1; bus.i_memwrite = 1'b1; bus.i_address = 32'h10; bus.i_datawrite = 32'h0;
        @(posedge clk); #1;
        chk("dbg", "word8", bus.o_dbg_data, model_word(8));
        chk("dbg", "ready_req", 32'(bus.o_ready), 32'd0);
        bus.i_valid = 1'b0; bus.i_memwrite = 1'b0;
        @(posedge clk); #1;
        bus.i_dbg_en = 1'b0;
        @(posedge clk); #1;
        chk("dbg", "ready_exit", 32'(bus.o_ready), 32'd1);
        chk("dbg", "hold", bus.o_dbg_data, model_word(8));
        op("lw10c", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);

        // Reset asserted while a load is waiting on the RAM
        bus.i_valid = 1'b1; bus.i_memread = 1'b1; bus.i_sizemem = 2'b11; bus.i_address = 32'h10;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_memread = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstrd", "rdvalid", 32'(bus.o_rdvalid), 32'd0);
        chk("rstrd", "data", bus.o_dataread, 32'd0);
        chk("rstrd", "ready", 32'(bus.o_ready), 32'd0);
        chk("rstrd", "dbg", bus.o_dbg_data, 32'd0);
        @(posedge clk); #1;
        chk("rstrd", "rdvalid_hold", 32'(bus.o_rdvalid), 32'd0);
        rst_n = 1'b1;
        last_data = 32'h0;
        last_code = 2'b00;
        @(posedge clk); #1;
        chk("rstrd", "ready_rel", 32'(bus.o_ready), 32'd1);
        chk("rstrd", "rdvalid_rel", 32'(bus.o_rdvalid), 32'd0);
        op("lw10r", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("lw10r", "const", bus.o_dataread, 32'hDEAD7FEF);

        for (int w = 0; w < 64; w++) op("init", 1'b0, 1'b1, 2'b11, 1'b0, 32'(w * 4), $urandom);
        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 255) : 32'($urandom_range(0, 255));
            d = $urandom;
            if (kind < 5)      op("rnd_ld", 1'b1, 1'b0, sz, 1'($urandom_range(0, 1)), a, d);
            else if (kind < 9) op("rnd_st", 1'b0, 1'b1, sz, 1'b0, a, d);
            else               op("rnd_odd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'b0, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
